// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock; `define SIGNED_DIV_EN for two's complement operands
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         Ready,
    output logic         Done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         DZ
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    state_t state, state_n;
    logic [N-1:0] rem, quo, dvs, sh, rem_n, quo_n, ma, mb, qf, rf;
    logic [N:0] trial;
    logic [CW-1:0] cnt;
    assign Ready = state == IDLE;
    assign sh = {rem[N-2:0], quo[N-1]};
    assign trial = {1'b0, sh} - {1'b0, dvs};
    assign rem_n = trial[N] ? sh : trial[N-1:0];
    assign quo_n = {quo[N-2:0], ~trial[N]};
`ifdef SIGNED_DIV_EN
    logic sq, sr;
    assign ma = A[N-1] ? -A : A;
    assign mb = B[N-1] ? -B : B;
    assign qf = sq ? -quo_n : quo_n;
    assign rf = sr ? -rem_n : rem_n;
    // sign flags captured with the operands; quotient sign is the xor, remainder follows the dividend
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq <= 1'b0;
            sr <= 1'b0;
        end else if (state == IDLE && Start) begin
            sq <= A[N-1] ^ B[N-1];
            sr <= A[N-1];
        end
    end
`else
    assign ma = A;
    assign mb = B;
    assign qf = quo_n;
    assign rf = rem_n;
`endif
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // next state: divide by zero skips straight to FIN
    always_comb begin
        state_n = IDLE;
        if (state == IDLE && Start) state_n = (B == '0) ? FIN : RUN;
        else if (state == RUN) state_n = (cnt == LAST) ? FIN : RUN;
    end
    // working registers: load on accept, one restoring step per RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (state == IDLE && Start) begin
            rem <= '0;
            quo <= ma;
            dvs <= mb;
            cnt <= '0;
        end else if (state == RUN) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
        end
    end
    // result registers only move on the edge entering FIN; entering from IDLE means divide by zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Done <= 1'b0;
            Q    <= '0;
            R    <= '0;
            DZ   <= 1'b0;
        end else begin
            Done <= state_n == FIN;
            if (state_n == FIN) begin
                Q  <= (state == IDLE) ? '1 : qf;
                R  <= (state == IDLE) ? A : rf;
                DZ <= state == IDLE;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of results, latency, handshake and reset abort
module tb_seq_divider;
    logic clk = 1'b0;
    logic reset, Start, Ready, Done, DZ;
    logic [31:0] A, B, Q, R;
    int n_chk = 0;
    int n_fail = 0;

    seq_divider #(.N(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .A(A), .B(B),
        .Ready(Ready), .Done(Done), .Q(Q), .R(R), .DZ(DZ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // counts cycles after the accepting edge until Done, bounded
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!Done && k < 40);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic edz, input int lat);
        int k;
        @(negedge clk);
        A = a;
        B = b;
        Start = 1'b1;
        check("ready_before", Ready, 1);
        @(posedge clk);
        #1 Start = 1'b0;
        wait_done(k);
        check("latency", k, lat);
        check("q", Q, eq);
        check("r", R, er);
        check("dz", DZ, edz);
        @(negedge clk);
        check("done_pulse", Done, 0);
        check("ready_after", Ready, 1);
    endtask

    initial begin
        int k, nd;
        reset = 1'b1;
        Start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", Ready, 1);
        check("rst_done", Done, 0);
        check("rst_q", Q, 0);
        check("rst_r", R, 0);
        check("rst_dz", DZ, 0);
        reset = 1'b0;

        do_div(100, 7, 14, 2, 0, 33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_q", Q, 14);
            check("hold_r", R, 2);
            check("hold_done", Done, 0);
        end
        do_div(32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0, 33);
        do_div(5, 9, 0, 5, 0, 33);
        do_div(0, 3, 0, 0, 0, 33);
        do_div(1234, 0, 32'hFFFFFFFF, 1234, 1, 1);
        do_div(10, 3, 3, 1, 0, 33);

        // Start held through the run with operands changed mid-run
        @(negedge clk);
        A = 50;
        B = 5;
        Start = 1'b1;
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 10) begin
                A = 1000;
                B = 3;
            end
        end while (!Done && k < 40);
        check("held_latency", k, 33);
        check("held_q", Q, 10);
        check("held_r", R, 0);
        @(negedge clk);
        check("held_done_pulse", Done, 0);
        check("held_ready", Ready, 1);
        @(posedge clk);
        #1 Start = 1'b0;
        wait_done(k);
        check("held2_latency", k, 33);
        check("held2_q", Q, 333);
        check("held2_r", R, 1);
        @(negedge clk);

        // reset mid-run aborts without a Done
        @(negedge clk);
        A = 100;
        B = 7;
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready", Ready, 1);
        check("abort_done", Done, 0);
        check("abort_q", Q, 0);
        check("abort_r", R, 0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) nd++;
        end
        check("abort_no_done", nd, 0);
        do_div(77, 7, 11, 0, 0, 33);

`ifdef SIGNED_DIV_EN
        do_div(32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 33);
        do_div(7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 0, 33);
        do_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 33);
`else
        do_div(32'hFFFFFFF9, 2, 32'h7FFFFFFC, 1, 0, 33);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
